// File: rtl/ccu_pkg.sv
// ccu_pkg: shared definitions for the multi-crosswalk control unit.
//   state_t        - controller phase (IDLE, GREEN, ORANGE, CLEAR)
//   timer_width()  - phase timer width for the longest phase, minimum 1 bit
//   ch_width()     - channel index width, minimum 1 bit
package ccu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    ORANGE = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  // The timer is loaded with duration-1, so clog2 of the longest duration
  // is enough to hold it.
  function automatic int timer_width(input int g, input int o, input int c);
    int m;
    m = g;
    if (o > m) m = o;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccu_multi_timer.sv
// phase_timer: loadable down-counter used to time each walk phase.
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-low reset
//   load       in  load load_value this cycle (takes priority over counting)
//   load_value in  W-bit value to load (phase duration - 1)
//   zero       out count currently reads 0
module phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Saturates at zero so an idle controller leaves the timer parked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/ccu_multi.sv
// ccu_multi: one FSM and one shared phase timer serving NCH crossings.
// Button presses are latched per channel and granted round-robin; each grant
// runs green -> orange -> all-red clearance, then returns to IDLE.
//   clk          in  clock, rising edge
//   reset        in  asynchronous active-low reset
//   req          in  NCH pedestrian buttons (level, sampled on clk)
//   green_walk   out NCH walk permitted
//   orange_walk  out NCH walk ending
//   red_hand     out NCH do not walk
//   active_ch    out channel being served (valid when busy)
//   busy         out FSM not in IDLE
module ccu_multi
  import ccu_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int TVALUE      = 4,
  parameter int GREEN_MULT  = 3,
  parameter int ORANGE_MULT = 1,
  parameter int CLEAR_MULT  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH-1:0]             req,
  output logic [NCH-1:0]             green_walk,
  output logic [NCH-1:0]             orange_walk,
  output logic [NCH-1:0]             red_hand,
  output logic [ch_width(NCH)-1:0]   active_ch,
  output logic                       busy
);

  localparam int CW = ch_width(NCH);
  localparam int G  = GREEN_MULT * TVALUE;
  localparam int O  = ORANGE_MULT * TVALUE;
  localparam int C  = CLEAR_MULT * TVALUE;
  localparam int TW = timer_width(G, O, C);

  localparam logic [TW-1:0] G_LOAD = TW'(G - 1);
  localparam logic [TW-1:0] O_LOAD = TW'(O - 1);
  localparam logic [TW-1:0] C_LOAD = TW'(C - 1);

  state_t          state_reg, state_next;
  logic [NCH-1:0]  pending_reg, pending_next;
  logic [CW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]   active_ch_reg, active_ch_next;

  logic            timer_load;
  logic [TW-1:0]   timer_load_value;
  logic            timer_zero;

  logic            grant_valid, grant_fire;
  logic [CW-1:0]   grant_idx;
  logic [NCH-1:0]  set_mask, clear_mask;

  phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .zero       (timer_zero)
  );

  // Round-robin pick: lowest pending index at or above rr_ptr, else wrap to
  // the lowest pending index overall.
  always_comb begin
    logic          hi_valid, lo_valid;
    logic [CW-1:0] hi_idx, lo_idx;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        lo_valid = 1'b1;
        lo_idx   = CW'(i);
        if (i >= int'(rr_ptr_reg)) begin
          hi_valid = 1'b1;
          hi_idx   = CW'(i);
        end
      end
    end
    grant_valid = hi_valid | lo_valid;
    grant_idx   = hi_valid ? hi_idx : lo_idx;
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    active_ch_next   = active_ch_reg;
    timer_load       = 1'b0;
    timer_load_value = G_LOAD;
    grant_fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          grant_fire       = 1'b1;
          state_next       = GREEN;
          active_ch_next   = grant_idx;
          rr_ptr_next      = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
          timer_load       = 1'b1;
          timer_load_value = G_LOAD;
        end
      end
      GREEN: begin
        if (timer_zero) begin
          state_next       = ORANGE;
          timer_load       = 1'b1;
          timer_load_value = O_LOAD;
        end
      end
      ORANGE: begin
        if (timer_zero) begin
          state_next       = CLEAR;
          timer_load       = 1'b1;
          timer_load_value = C_LOAD;
        end
      end
      CLEAR: begin
        if (timer_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-channel latch control and output decode. A press on the channel
  // currently in GREEN is dropped; the channel being granted this edge
  // clears even if its button is still held.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign set_mask[gi]    = req[gi] &&
                             !((state_reg == GREEN) && (active_ch_reg == CW'(gi)));
    assign clear_mask[gi]  = grant_fire && (grant_idx == CW'(gi));
    assign green_walk[gi]  = (state_reg == GREEN)  && (active_ch_reg == CW'(gi));
    assign orange_walk[gi] = (state_reg == ORANGE) && (active_ch_reg == CW'(gi));
    assign red_hand[gi]    = ~(green_walk[gi] | orange_walk[gi]);
  end

  assign pending_next = (pending_reg | set_mask) & ~clear_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      rr_ptr_reg    <= '0;
      active_ch_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      rr_ptr_reg    <= rr_ptr_next;
      active_ch_reg <= active_ch_next;
    end
  end

  assign active_ch = active_ch_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ccu_multi.sv
module tb_ccu_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // a: defaults (NCH=2, TVALUE=4, 3/1/2)
  logic [1:0] req_a, green_a, orange_a, red_a;
  logic [0:0] act_a;
  logic       busy_a;
  // b: NCH=1, everything 1
  logic [0:0] req_b, green_b, orange_b, red_b;
  logic [0:0] act_b;
  logic       busy_b;
  // c: NCH=3, TVALUE=1, green 2, orange 1, clear 1
  logic [2:0] req_c, green_c, orange_c, red_c;
  logic [1:0] act_c;
  logic       busy_c;

  int n_cmp = 0;
  int n_bad = 0;

  ccu_multi dut_a (
    .clk(clk), .reset(reset), .req(req_a), .green_walk(green_a),
    .orange_walk(orange_a), .red_hand(red_a), .active_ch(act_a), .busy(busy_a)
  );

  ccu_multi #(.NCH(1), .TVALUE(1), .GREEN_MULT(1), .ORANGE_MULT(1), .CLEAR_MULT(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .green_walk(green_b),
    .orange_walk(orange_b), .red_hand(red_b), .active_ch(act_b), .busy(busy_b)
  );

  ccu_multi #(.NCH(3), .TVALUE(1), .GREEN_MULT(2), .ORANGE_MULT(1), .CLEAR_MULT(1)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .green_walk(green_c),
    .orange_walk(orange_c), .red_hand(red_c), .active_ch(act_c), .busy(busy_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_a = '0; req_b = '0; req_c = '0;
    repeat (3) step();
    n_cmp++;
    if ({green_a, orange_a, red_a, busy_a} !== 7'b00_00_11_0) begin
      n_bad++; $display("FAIL reset_a: got %b expected %b", {green_a, orange_a, red_a, busy_a}, 7'b00_00_11_0);
    end
    n_cmp++;
    if (act_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_act_a: got %0d expected 0", act_a);
    end
    n_cmp++;
    if ({green_b, orange_b, red_b, busy_b} !== 4'b0010) begin
      n_bad++; $display("FAIL reset_b: got %b expected 0010", {green_b, orange_b, red_b, busy_b});
    end
    n_cmp++;
    if ({green_c, orange_c, red_c, busy_c} !== 10'b000_000_111_0) begin
      n_bad++; $display("FAIL reset_c: got %b expected 0000001110", {green_c, orange_c, red_c, busy_c});
    end
    reset = 1'b1;
    step();
    // get channel 1 into GREEN, then reset asynchronously mid-phase
    req_a = 2'b10; step(); req_a = 2'b00; step(); step();
    n_cmp++;
    if (green_a !== 2'b10) begin
      n_bad++; $display("FAIL pre_reset_green: got %b expected 10", green_a);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({green_a, orange_a, red_a, busy_a} !== 7'b00_00_11_0) begin
      n_bad++; $display("FAIL async_reset: got %b expected %b", {green_a, orange_a, red_a, busy_a}, 7'b00_00_11_0);
    end
    step();
    reset = 1'b1;
    repeat (4) step();
    n_cmp++;
    if ({busy_a, red_a} !== 3'b0_11) begin
      n_bad++; $display("FAIL post_reset_idle: got %b expected 011", {busy_a, red_a});
    end
  endtask

  task automatic test_single();
    logic [6:0] exp_v;
    req_a = 2'b01; step(); req_a = 2'b00;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: got busy=%b expected 0", busy_a);
    end
    for (int t = 0; t < 24; t++) begin
      step();
      if (t < 12)      exp_v = 7'b01_00_10_1;
      else if (t < 16) exp_v = 7'b00_01_10_1;
      else             exp_v = 7'b00_00_11_1;
      n_cmp++;
      if ({green_a, orange_a, red_a, busy_a} !== exp_v) begin
        n_bad++; $display("FAIL single_t%0d: got %b expected %b", t, {green_a, orange_a, red_a, busy_a}, exp_v);
      end
    end
    step();
    n_cmp++;
    if ({green_a, orange_a, red_a, busy_a} !== 7'b00_00_11_0) begin
      n_bad++; $display("FAIL single_end: got %b expected 0000110", {green_a, orange_a, red_a, busy_a});
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] g, o;
    logic       b;
    int         ch, p;
    reset = 1'b0; step(); reset = 1'b1; step();
    req_a = 2'b11; step(); req_a = 2'b00;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL simul_latency: got busy=%b expected 0", busy_a);
    end
    for (int t = 0; t < 50; t++) begin
      step();
      ch = (t < 24) ? 0 : 1;
      p  = (t < 24) ? t : t - 25;
      g = 2'b00; o = 2'b00; b = 1'b1;
      if (t == 24 || t == 49) b = 1'b0;
      else if (p < 12) g = 2'(1 << ch);
      else if (p < 16) o = 2'(1 << ch);
      n_cmp++;
      if ({green_a, orange_a, red_a, busy_a} !== {g, o, ~(g | o), b}) begin
        n_bad++; $display("FAIL simul_t%0d: got %b expected %b", t, {green_a, orange_a, red_a, busy_a}, {g, o, ~(g | o), b});
      end
      if (b) begin
        n_cmp++;
        if (act_a !== 1'(ch)) begin
          n_bad++; $display("FAIL simul_act_t%0d: got %0d expected %0d", t, act_a, ch);
        end
      end
    end
    // second pair: pointer has wrapped, so channel 0 goes first again
    req_a = 2'b11; step(); req_a = 2'b00;
    step();
    n_cmp++;
    if ({green_a, act_a} !== 3'b01_0) begin
      n_bad++; $display("FAIL simul_wrap: got %b expected 010", {green_a, act_a});
    end
    repeat (49) step();
    n_cmp++;
    if ({busy_a, red_a} !== 3'b0_11) begin
      n_bad++; $display("FAIL simul_drain: got %b expected 011", {busy_a, red_a});
    end
  endtask

  task automatic test_repress();
    // re-press during GREEN: dropped
    req_a = 2'b01; step(); req_a = 2'b00; step();
    repeat (4) step();
    req_a = 2'b01; step(); req_a = 2'b00;
    repeat (19) step();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL green_press_end: got busy=%b expected 0", busy_a);
    end
    repeat (3) step();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL green_press_dropped: got busy=%b expected 0", busy_a);
    end
    // re-press during CLEAR: latched, second sequence after one IDLE cycle
    req_a = 2'b01; step(); req_a = 2'b00; step();
    repeat (18) step();
    req_a = 2'b01; step(); req_a = 2'b00;
    repeat (4) step();
    n_cmp++;
    if ({red_a, busy_a} !== 3'b11_1) begin
      n_bad++; $display("FAIL clear_press_last: got %b expected 111", {red_a, busy_a});
    end
    step();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL clear_press_idle: got busy=%b expected 0", busy_a);
    end
    step();
    n_cmp++;
    if ({green_a, act_a, busy_a} !== 4'b01_0_1) begin
      n_bad++; $display("FAIL clear_press_regrant: got %b expected 0101", {green_a, act_a, busy_a});
    end
    repeat (24) step();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL clear_press_end: got busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_nch1();
    logic [3:0] exp_v;
    req_b = 1'b1; step();
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_bad++; $display("FAIL nch1_latency: got busy=%b expected 0", busy_b);
    end
    for (int t = 0; t < 12; t++) begin
      step();
      case (t % 4)
        0:       exp_v = 4'b1001;
        1:       exp_v = 4'b0101;
        2:       exp_v = 4'b0011;
        default: exp_v = 4'b0010;
      endcase
      n_cmp++;
      if ({green_b, orange_b, red_b, busy_b} !== exp_v) begin
        n_bad++; $display("FAIL nch1_t%0d: got %b expected %b", t, {green_b, orange_b, red_b, busy_b}, exp_v);
      end
    end
    req_b = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_bad++; $display("FAIL nch1_stop: got busy=%b expected 0", busy_b);
    end
  endtask

  task automatic test_nch3();
    logic [2:0] g, o;
    logic       b;
    int         ch, ph;
    req_c = 3'b010; step(); req_c = 3'b000;
    for (int t = 0; t < 15; t++) begin
      step();
      ph = t % 5;
      case (t / 5)
        0:       ch = 1;
        1:       ch = 2;
        default: ch = 0;
      endcase
      g = 3'b000; o = 3'b000; b = (ph != 4);
      if (ph < 2)       g = 3'(1 << ch);
      else if (ph == 2) o = 3'(1 << ch);
      n_cmp++;
      if ({green_c, orange_c, red_c, busy_c} !== {g, o, ~(g | o), b}) begin
        n_bad++; $display("FAIL nch3_t%0d: got %b expected %b", t, {green_c, orange_c, red_c, busy_c}, {g, o, ~(g | o), b});
      end
      if (b) begin
        n_cmp++;
        if (act_c !== 2'(ch)) begin
          n_bad++; $display("FAIL nch3_act_t%0d: got %0d expected %0d", t, act_c, ch);
        end
      end
      if (t == 0) req_c = 3'b101;
      if (t == 1) req_c = 3'b000;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_repress();
    test_nch1();
    test_nch3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccu_multi.md
# ccu_multi

Multi-crosswalk control unit: one FSM and one shared phase timer serve NCH independent pedestrian crossings. Pending button requests are latched per channel, granted round-robin, and the walk sequence green → orange → all-red clearance runs with durations that are integer multiples of a base unit TVALUE. This generalises the single-crossing controller plus parametrised counter pair into one parametrised block, adding request latching and fair arbitration.

## Interface
- NCH, 2: number of crossings (≥1)
- TVALUE, 4: base time unit in clk cycles (≥1)
- GREEN_MULT, 3: green_walk duration in units (≥1)
- ORANGE_MULT, 1: orange_walk duration in units (≥1)
- CLEAR_MULT, 2: all-red clearance duration in units (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NCH  pedestrian buttons, level, sampled on clk
- green_walk  out  NCH  walk permitted on channel i
- orange_walk  out  NCH  walk ending on channel i
- red_hand  out  NCH  do not walk on channel i
- active_ch  out  max(1,$clog2(NCH))  channel currently served (valid when busy)
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, GREEN, ORANGE, CLEAR.
- pending[NCH-1:0]: bit i set on any edge where req[i]=1; cleared when channel i is granted; set has priority over clear for other channels only.
- IDLE: if pending≠0, grant the first set bit at or after rr_ptr (wrapping), load active_ch, clear that pending bit, rr_ptr ← grant+1 mod NCH, go GREEN. Otherwise stay.
- GREEN → ORANGE → CLEAR → IDLE, each after its full duration.
- req[active_ch] during GREEN is discarded; during ORANGE/CLEAR it is latched.
- Outputs (decoded from registered state/active_ch, exactly one-hot per channel): channel active_ch shows green_walk in GREEN, orange_walk in ORANGE; every other channel, and all channels in IDLE/CLEAR, show red_hand.
- Reset (any time): state=IDLE, pending=0, rr_ptr=0, active_ch=0, timer=0; outputs red_hand=all ones, green_walk=0, orange_walk=0, busy=0.

## Timing
- Durations: G=GREEN_MULT·TVALUE, O=ORANGE_MULT·TVALUE, C=CLEAR_MULT·TVALUE cycles, exact.
- Timer: down-counter loaded with duration−1 on state entry; transition on the edge where it reads 0. Width = $clog2(max(G,O,C)), minimum 1.
- Latency: req[i] high at edge k → pending[i] after k → GREEN visible after edge k+1 (FSM idle).
- IDLE lasts ≥1 cycle between sequences; back-to-back pending requests start GREEN one cycle after CLEAR ends.
- Simultaneous requests: served in round-robin order from rr_ptr; no channel is served twice before every pending channel has been served once.
- Duration of 1 (all params 1): each phase lasts exactly 1 cycle.
- Async reset assertion mid-phase forces outputs to reset values immediately; deassertion is synchronised by the caller.

## Structure
- Shared package ccu_pkg: state enum (IDLE, GREEN, ORANGE, CLEAR), localparam for timer width function.
- Sub-module phase_timer: loadable down-counter (load, value, zero flag), parametrised width.
- Arbiter and FSM are in ccu_multi itself.

## Test plan
- Reset: hold reset=0 for 3 cycles → red_hand=2'b11, green_walk=0, orange_walk=0, busy=0; reassert mid-GREEN → same values the same cycle.
- Single request (defaults): req[0] pulse 1 cycle at edge k → green_walk[0] for cycles k+1..k+12, orange_walk[0] for 4, red_hand[0] 8 clearance cycles, then busy=0.
- Simultaneous req=2'b11 from reset → channel 0 full sequence (24 cycles), 1 IDLE cycle, then channel 1; next simultaneous pair starts with channel 0 again (rr_ptr wrapped).
- Re-press during GREEN on active channel → discarded, no second sequence; re-press during CLEAR → second sequence for same channel after one IDLE cycle.
- NCH=1, TVALUE=1, all multipliers 1, req held high → repeating green 1, orange 1, clear 1, idle 1 (period 4 cycles).
- NCH=3, requests on 2 then 0 while serving 1 → grant order 2, 0 (rr_ptr=2 after serving 1).
